register_file: RTL and testbench

- General-purpose register file for the CPU datapath: one synchronous write port and two independent combinational read ports.
- Each read port drives a shared tri-state bus (a_bus, b_bus) only when its output enable is asserted; otherwise it releases the bus.
- The write address is shared with read port A (sel_a); data is written from input_bus.

---
 rtl/register_file.sv | 71 +++++++
 tb/tb_register_file.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports that drive shared tri-state buses only while enabled.
module register_file #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SEL_WIDTH = 8,
   parameter int unsigned NUM_REGS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld,
   input  logic                 oe_a,
   input  logic                 oe_b,
   input  logic [SEL_WIDTH-1:0] sel_a,
   input  logic [SEL_WIDTH-1:0] sel_b,
   input  logic [WIDTH-1:0]     input_bus,
   inout  wire  [WIDTH-1:0]     a_bus,
   inout  wire  [WIDTH-1:0]     b_bus
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned CMP_W = SEL_WIDTH + 1;

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];

   logic             a_in_range_c;
   logic             b_in_range_c;
   logic [IDX_W-1:0] a_idx_c;
   logic [IDX_W-1:0] b_idx_c;
   logic [WIDTH-1:0] a_rd_c;
   logic [WIDTH-1:0] b_rd_c;

   // Out-of-range selects never alias onto an implemented register.
   assign a_in_range_c = (CMP_W'(sel_a) < CMP_W'(NUM_REGS));
   assign b_in_range_c = (CMP_W'(sel_b) < CMP_W'(NUM_REGS));
   assign a_idx_c      = IDX_W'(sel_a);
   assign b_idx_c      = IDX_W'(sel_b);

   always_comb begin
      regs_d = regs_q;
      if (ld && a_in_range_c) begin
         regs_d[a_idx_c] = input_bus;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads come straight from storage, so a write shows only after its edge.
   always_comb begin
      a_rd_c = '0;
      b_rd_c = '0;
      if (a_in_range_c) begin
         a_rd_c = regs_q[a_idx_c];
      end
      if (b_in_range_c) begin
         b_rd_c = regs_q[b_idx_c];
      end
   end

   assign a_bus = oe_a ? a_rd_c : {WIDTH{1'bz}};
   assign b_bus = oe_b ? b_rd_c : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; buses carry pull-ups so a released bus
// reads all ones while a driven bus reads the register contents.
module tb_register_file;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned SEL_WIDTH = 8;
   localparam int unsigned NUM_REGS  = 16;
   localparam logic [WIDTH-1:0] RELEASED = {WIDTH{1'b1}};

   logic                 clk;
   logic                 rst;
   logic                 ld;
   logic                 oe_a;
   logic                 oe_b;
   logic [SEL_WIDTH-1:0] sel_a;
   logic [SEL_WIDTH-1:0] sel_b;
   logic [WIDTH-1:0]     input_bus;
   wire  [WIDTH-1:0]     a_bus;
   wire  [WIDTH-1:0]     b_bus;

   int n_checks;
   int n_fail;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_pu
      pullup (a_bus[i]);
      pullup (b_bus[i]);
   end

   register_file #(
      .WIDTH     (WIDTH),
      .SEL_WIDTH (SEL_WIDTH),
      .NUM_REGS  (NUM_REGS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ld        (ld),
      .oe_a      (oe_a),
      .oe_b      (oe_b),
      .sel_a     (sel_a),
      .sel_b     (sel_b),
      .input_bus (input_bus),
      .a_bus     (a_bus),
      .b_bus     (b_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic write_reg(input int sel, input int data);
      @(negedge clk);
      ld        = 1'b1;
      sel_a     = SEL_WIDTH'(sel);
      input_bus = WIDTH'(data);
      @(posedge clk);
      #1;
      ld = 1'b0;
   endtask

   task automatic read_a(input string tag, input int sel, input int exp);
      oe_a  = 1'b1;
      sel_a = SEL_WIDTH'(sel);
      #1;
      check_eq(tag, a_bus, WIDTH'(exp));
   endtask

   task automatic read_b(input string tag, input int sel, input int exp);
      oe_b  = 1'b1;
      sel_b = SEL_WIDTH'(sel);
      #1;
      check_eq(tag, b_bus, WIDTH'(exp));
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      ld        = 1'b0;
      oe_a      = 1'b0;
      oe_b      = 1'b0;
      sel_a     = '0;
      sel_b     = '0;
      input_bus = '0;

      // reset state
      #2;
      read_a("rst_a0", 0, 0);
      read_b("rst_b15", 15, 0);
      @(negedge clk);
      rst  = 1'b0;
      oe_a = 1'b0;
      oe_b = 1'b0;

      // basic write/read
      write_reg(2, 123);
      read_a("basic_a2", 2, 123);
      read_b("basic_b2", 2, 123);

      // independent registers and overwrite
      write_reg(3, 321);
      write_reg(2, 567);
      read_a("ovw_a3", 3, 321);
      read_b("ovw_b3", 3, 321);
      read_a("ovw_a2", 2, 567);
      read_b("ovw_b2", 2, 567);

      // tri-state release, then simultaneous reads of different registers
      oe_a  = 1'b0;
      oe_b  = 1'b0;
      sel_a = 8'd2;
      sel_b = 8'd0;
      #1;
      check_eq("rel_a", a_bus, RELEASED);
      check_eq("rel_b", b_bus, RELEASED);
      oe_a  = 1'b1;
      sel_a = 8'd2;
      oe_b  = 1'b1;
      sel_b = 8'd3;
      #1;
      check_eq("dual_a2", a_bus, WIDTH'(567));
      check_eq("dual_b3", b_bus, WIDTH'(321));

      // ld=0 blocks the write
      @(negedge clk);
      ld        = 1'b0;
      sel_a     = 8'd2;
      input_bus = WIDTH'(999);
      @(posedge clk);
      #1;
      read_a("noload_a2", 2, 567);

      // out-of-range write ignored; out-of-range read gives zero
      write_reg(200, 999);
      read_a("oor_rd_a", 200, 0);
      read_b("oor_rd_b", 200, 0);
      read_a("oor_alias8", 8, 0);
      read_a("oor_keep2", 2, 567);
      read_b("oor_keep3", 3, 321);

      // asynchronous reset between edges
      @(negedge clk);
      #2;
      oe_a  = 1'b1;
      sel_a = 8'd2;
      oe_b  = 1'b1;
      sel_b = 8'd3;
      rst   = 1'b1;
      #1;
      check_eq("arst_a2", a_bus, '0);
      check_eq("arst_b3", b_bus, '0);
      ld        = 1'b1;
      input_bus = WIDTH'(777);
      @(posedge clk);
      #1;
      ld = 1'b0;
      check_eq("arst_ldblk", a_bus, '0);
      @(negedge clk);
      rst = 1'b0;
      read_a("arst_after", 2, 0);

      // read-during-write: old value before the edge, new after
      write_reg(5, 10);
      read_b("rdw_b5_init", 5, 10);
      @(negedge clk);
      oe_a      = 1'b1;
      sel_a     = 8'd5;
      ld        = 1'b1;
      input_bus = WIDTH'(20);
      #1;
      check_eq("rdw_before", a_bus, WIDTH'(10));
      check_eq("rdw_before_b", b_bus, WIDTH'(10));
      @(posedge clk);
      #1;
      ld = 1'b0;
      check_eq("rdw_after", a_bus, WIDTH'(20));
      check_eq("rdw_after_b", b_bus, WIDTH'(20));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
